// File: rtl/scanline_irq_unit.sv
// Scanline IRQ unit: filters PPU A12 rising edges and runs an MMC3-style
// reloadable down-counter that raises a sticky interrupt request at zero.
module scanline_irq_unit #(
  parameter int unsigned A12_LOW_MIN = 3,
  parameter bit          OLD_STYLE   = 1'b0
) (
  input  logic       m2,
  input  logic       rst,
  input  logic       unit_en,
  input  logic       wr_stb,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       ppu_a12,
  output logic       irq_out,
  output logic [7:0] counter_dbg
);

  localparam logic [2:0] LOW_MIN = 3'(A12_LOW_MIN);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [2:0] low_cnt_q, low_cnt_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] counter_q, counter_d;
  logic       reload_pending_q, reload_pending_d;
  logic       enabled_q, enabled_d;
  logic       irq_q, irq_d;

  logic       a12_s;
  logic       a12_rise;
  logic       wr_hit;
  logic       wr_latch, wr_reload, wr_disable, wr_enable;
  logic [7:0] rise_counter;
  logic       rise_reload;
  logic       irq_set;

  // Synchronize A12 and qualify its rising edges by how long it stayed low
  always_comb begin
    sync1_d  = ppu_a12;
    sync2_d  = sync1_q;
    a12_s    = sync2_q;
    a12_rise = a12_s && (low_cnt_q >= LOW_MIN);
    if (a12_s) begin
      low_cnt_d = 3'd0;
    end else if (low_cnt_q == 3'd7) begin
      low_cnt_d = 3'd7;
    end else begin
      low_cnt_d = low_cnt_q + 3'd1;
    end
  end

  // Register decode, counter update and IRQ logic; writes take priority over a12_rise
  always_comb begin
    wr_hit     = wr_stb && unit_en && wr_addr[2];
    wr_latch   = wr_hit && (wr_addr[1:0] == 2'b00);
    wr_reload  = wr_hit && (wr_addr[1:0] == 2'b01);
    wr_disable = wr_hit && (wr_addr[1:0] == 2'b10);
    wr_enable  = wr_hit && (wr_addr[1:0] == 2'b11);

    latch_d          = latch_q;
    counter_d        = counter_q;
    reload_pending_d = reload_pending_q;
    enabled_d        = enabled_q;
    irq_d            = irq_q;
    irq_set          = 1'b0;

    // A reload always uses the latch value from before any same-cycle write
    rise_reload  = (counter_q == 8'd0) || reload_pending_q;
    rise_counter = rise_reload ? latch_q : (counter_q - 8'd1);

    if (a12_rise) begin
      counter_d        = rise_counter;
      reload_pending_d = 1'b0;
      // The old variant only signals a count that decremented down to zero
      irq_set = (rise_counter == 8'd0) && enabled_q &&
                (!OLD_STYLE || !rise_reload);
    end

    if (wr_latch) begin
      latch_d = wr_data;
    end
    if (wr_reload) begin
      counter_d        = 8'd0;
      reload_pending_d = 1'b1;
      irq_set          = 1'b0;
    end
    if (wr_enable) begin
      enabled_d = 1'b1;
    end

    if (irq_set) begin
      irq_d = 1'b1;
    end
    if (wr_disable) begin
      enabled_d = 1'b0;
      irq_d     = 1'b0;
    end
    if (!unit_en) begin
      irq_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge m2) begin
    if (rst) begin
      sync1_q          <= 1'b0;
      sync2_q          <= 1'b0;
      low_cnt_q        <= 3'd0;
      latch_q          <= 8'd0;
      counter_q        <= 8'd0;
      reload_pending_q <= 1'b0;
      enabled_q        <= 1'b0;
      irq_q            <= 1'b0;
    end else begin
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      low_cnt_q        <= low_cnt_d;
      latch_q          <= latch_d;
      counter_q        <= counter_d;
      reload_pending_q <= reload_pending_d;
      enabled_q        <= enabled_d;
      irq_q            <= irq_d;
    end
  end

  assign irq_out     = irq_q;
  assign counter_dbg = counter_q;

endmodule

// File: tb/tb_scanline_irq_unit.sv
// Directed bench for scanline_irq_unit: one instance per counter variant,
// both driven by the same stimulus.
module tb_scanline_irq_unit;

  logic       m2 = 1'b0;
  logic       rst;
  logic       unit_en;
  logic       wr_stb;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       ppu_a12;
  logic       irq_new, irq_old;
  logic [7:0] cnt_new, cnt_old;

  int compared   = 0;
  int mismatched = 0;

  scanline_irq_unit #(.A12_LOW_MIN(3), .OLD_STYLE(1'b0)) dut_new (
    .m2(m2), .rst(rst), .unit_en(unit_en), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .ppu_a12(ppu_a12), .irq_out(irq_new), .counter_dbg(cnt_new)
  );

  scanline_irq_unit #(.A12_LOW_MIN(3), .OLD_STYLE(1'b1)) dut_old (
    .m2(m2), .rst(rst), .unit_en(unit_en), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .ppu_a12(ppu_a12), .irq_out(irq_old), .counter_dbg(cnt_old)
  );

  // Free-running m2 clock
  always #5 m2 = ~m2;

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle CPU register write
  task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
    wr_stb  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_stb  = 1'b0;
  endtask

  // A12 low for low_cycles m2 cycles, then high long enough to settle
  task automatic a12Edge(input int low_cycles);
    ppu_a12 = 1'b0;
    repeat (low_cycles) tick();
    ppu_a12 = 1'b1;
    repeat (4) tick();
  endtask

  // Qualified A12 edge with a register write landing on the same m2 edge as a12_rise
  task automatic coincidentWrite(input logic [2:0] addr, input logic [7:0] data);
    ppu_a12 = 1'b0;
    repeat (4) tick();
    ppu_a12 = 1'b1;
    tick();
    tick();
    applyStimulus(addr, data);
    repeat (2) tick();
  endtask

  initial begin
    rst     = 1'b1;
    unit_en = 1'b1;
    wr_stb  = 1'b0;
    wr_addr = 3'b000;
    wr_data = 8'd0;
    ppu_a12 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    checkOutput("reset_cnt", cnt_new, 0);
    checkOutput("reset_irq_new", irq_new, 0);
    checkOutput("reset_irq_old", irq_old, 0);

    // latch=3, reload, enable, then five qualified edges
    applyStimulus(3'b100, 8'd3);
    applyStimulus(3'b101, 8'd0);
    applyStimulus(3'b111, 8'd0);
    a12Edge(4); checkOutput("seq_e1_cnt", cnt_new, 3); checkOutput("seq_e1_irq", irq_new, 0);
    a12Edge(4); checkOutput("seq_e2_cnt", cnt_new, 2);
    a12Edge(4); checkOutput("seq_e3_cnt", cnt_new, 1); checkOutput("seq_e3_irq", irq_new, 0);
    a12Edge(4); checkOutput("seq_e4_cnt", cnt_new, 0);
    checkOutput("seq_e4_irq_new", irq_new, 1); checkOutput("seq_e4_irq_old", irq_old, 1);
    a12Edge(4); checkOutput("seq_e5_cnt", cnt_old, 3); checkOutput("seq_e5_irq_sticky", irq_new, 1);

    // $E000 clears; enabling at counter 0 must not re-arm
    applyStimulus(3'b110, 8'd0);
    checkOutput("e000_irq_new", irq_new, 0);
    checkOutput("e000_irq_old", irq_old, 0);
    a12Edge(4); a12Edge(4); a12Edge(4);
    checkOutput("disabled_cnt", cnt_new, 0);
    checkOutput("disabled_irq", irq_new, 0);
    applyStimulus(3'b111, 8'd0);
    repeat (2) tick();
    checkOutput("e001_no_rearm", irq_new, 0);

    // Short low periods are ignored
    applyStimulus(3'b110, 8'd0);
    applyStimulus(3'b101, 8'd0);
    a12Edge(4); checkOutput("filt_reload", cnt_new, 3);
    a12Edge(2); checkOutput("filt_low2", cnt_new, 3);
    a12Edge(3); checkOutput("filt_low3", cnt_new, 2);

    // $C001 beats a coincident decrement; pending reload loads the latch next
    applyStimulus(3'b100, 8'd7);
    applyStimulus(3'b101, 8'd0);
    a12Edge(4); a12Edge(4); a12Edge(4);
    checkOutput("pre_coinc_cnt", cnt_new, 5);
    coincidentWrite(3'b101, 8'd0);
    checkOutput("coinc_c001_cnt", cnt_new, 0);
    a12Edge(4); checkOutput("pending_reload", cnt_new, 7);

    // Latch write on a reload edge: the reload uses the old latch value
    applyStimulus(3'b101, 8'd0);
    coincidentWrite(3'b100, 8'd9);
    checkOutput("coinc_latch_old", cnt_new, 7);
    applyStimulus(3'b101, 8'd0);
    a12Edge(4); checkOutput("coinc_latch_new", cnt_new, 9);

    // latch=0: new variant fires on reload, old variant does not
    applyStimulus(3'b100, 8'd0);
    applyStimulus(3'b110, 8'd0);
    applyStimulus(3'b111, 8'd0);
    applyStimulus(3'b101, 8'd0);
    a12Edge(4);
    checkOutput("l0_cnt_old", cnt_old, 0);
    checkOutput("l0_irq_new", irq_new, 1);
    checkOutput("l0_irq_old", irq_old, 0);
    a12Edge(4);
    checkOutput("l0_irq_old_again", irq_old, 0);

    // Reset mid-count with IRQ asserted
    applyStimulus(3'b100, 8'd1);
    applyStimulus(3'b110, 8'd0);
    applyStimulus(3'b111, 8'd0);
    applyStimulus(3'b101, 8'd0);
    a12Edge(4); a12Edge(4);
    checkOutput("dec_to0_irq_old", irq_old, 1);
    applyStimulus(3'b100, 8'd2);
    a12Edge(4);
    checkOutput("pre_rst_cnt", cnt_new, 2);
    checkOutput("pre_rst_irq", irq_new, 1);
    rst = 1'b1;
    tick();
    checkOutput("rst_cnt", cnt_new, 0);
    checkOutput("rst_irq_new", irq_new, 0);
    checkOutput("rst_irq_old", irq_old, 0);
    rst = 1'b0;
    repeat (4) tick();
    applyStimulus(3'b111, 8'd0);
    applyStimulus(3'b101, 8'd0);
    a12Edge(4);
    checkOutput("post_rst_latch0_cnt", cnt_new, 0);
    checkOutput("post_rst_latch0_irq", irq_new, 1);

    // unit_en low forces IRQ off and ignores writes
    unit_en = 1'b0;
    tick();
    checkOutput("unit_en_off_irq", irq_new, 0);
    applyStimulus(3'b100, 8'd5);
    unit_en = 1'b1;
    applyStimulus(3'b101, 8'd0);
    a12Edge(4);
    checkOutput("ignored_latch_write", cnt_new, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
